cool_heat_fan_ctrl: RTL and testbench
=====================================

Name: cool_heat_fan_ctrl

Overview:
- Consumer side of the free-running 8-bit period counter in the cool/heat system.
- Takes the current temperature and the shared counter value.
- Runs a hysteresis FSM (IDLE/HEATING/COOLING) that drives heater and cooler enables.
- Generates a glitch-free fan PWM whose duty is chosen by temperature band and is updated only at counter wrap.

Parameters:
HEAT_ON, 15, temperature below which IDLE enters HEATING
HEAT_OFF, 20, temperature at/above which HEATING returns to IDLE
COOL_ON, 35, temperature above which IDLE enters COOLING
COOL_OFF, 25, temperature at/below which COOLING returns to IDLE
FAN_T1, 40, temperature at/above which fan uses DUTY_MID
FAN_T2, 45, temperature at/above which fan uses DUTY_HI
DUTY_LO, 64, fan duty in COOLING below FAN_T1
DUTY_MID, 128, fan duty for FAN_T1 <= temp < FAN_T2
DUTY_HI, 192, fan duty for temp >= FAN_T2
Parameter constraint: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON < FAN_T1 < FAN_T2.

Ports:
clk  input  1  clock, posedge
arst  input  1  reset; one clock; reset is synchronous and active-high
temperature  input  8  unsigned temperature, degrees C
count  input  8  free-running period counter value, 0..255, wraps
heater_on  output  1  heater enable
cooler_on  output  1  cooler enable
fan_pwm  output  1  fan PWM drive
fan_duty  output  8  duty currently applied to the PWM
mode  output  2  FSM state: 00 IDLE, 01 HEATING, 10 COOLING

Behaviour:
- Reset: arst sampled high on a clk edge clears all state. Mode=00; heater_on, cooler_on, fan_pwm = 0; fan_duty = 0. This holds regardless of count or temperature, including mid-period.
- FSM, one transition per clk edge, using unsigned compares:
  - IDLE: temp < HEAT_ON -> HEATING; else temp > COOL_ON -> COOLING; else stay.
  - HEATING: temp >= HEAT_OFF -> IDLE; otherwise stay. HEATING never goes directly to COOLING.
  - COOLING: temp <= COOL_OFF -> IDLE; otherwise stay. COOLING never goes directly to HEATING.
- heater_on = (mode==HEATING) and cooler_on = (mode==COOLING). Both are decoded from the registered state, so they change 1 cycle after the triggering temperature and are never both 1.
- Duty target, combinational from current state and temp:
  - COOLING: temp >= FAN_T2 -> DUTY_HI; temp >= FAN_T1 -> DUTY_MID; else DUTY_LO.
  - Any other state: 0.
- Duty latch: fan_duty <= target only on an edge where count==8'hFF; otherwise fan_duty holds. A new duty therefore takes effect from count==0. Leaving COOLING lets the fan finish the current period, then duty drops to 0.
- If count skips 8'hFF, no update occurs in that period. This is not an error.
- PWM: fan_pwm <= (count < fan_duty), registered. The value for counter value c appears on the edge after c (1-cycle latency).
  - Duty 0 gives constant 0.
  - Duty 255 gives high for 255 of 256 cycles.
  - High time per period = fan_duty cycles.
- Temperature may change every cycle with no settling requirement. FSM decisions use the value sampled at each edge.

Decomposition:
- Shared constants file cool_heat_defs: state encodings (IDLE/HEATING/COOLING) and default thresholds/duties, reused by the top-level smart-home module.
- One sub-module, pwm_compare. It holds the boundary-synchronous duty latch and the registered comparator (inputs clk, arst, count, duty_target; outputs fan_duty, fan_pwm).
- The FSM and duty-band selection stay in cool_heat_fan_ctrl.

Test Plan:
1. Counter running, temp=50, arst high 3 cycles -> all outputs 0, mode=00. Release with temp=22 -> remains IDLE for 300 cycles.
2. Boundary check from IDLE:
   - temp=15 -> stays IDLE.
   - temp=14 -> mode=01, heater_on=1 one cycle later.
   - temp=19 -> holds HEATING.
   - temp=20 -> IDLE next cycle.
   - temp=35 -> stays IDLE.
   - temp=36 -> mode=10.
3. temp=38 in COOLING -> fan_duty becomes 64 on the count==FF edge. fan_pwm is high exactly 64 consecutive cycles per 256, delayed 1 cycle from count 0..63.
4. At count=100 temp steps to 46 -> fan_duty stays 64 until the count==FF edge, then 192. Then temp=30 -> still COOLING. Then temp=25 -> mode=00 next cycle, and fan_duty goes to 0 at the next FF edge; the PWM completes the current period.
5. count jumps 0xF0 -> 0x05 (FF skipped) while target changes -> fan_duty unchanged until the next genuine FF.
6. arst pulsed at count=50 in COOLING with duty 128 -> next edge: all outputs 0. A reset pulse between clock edges (not sampled) has no effect.

Source files
------------

// File: rtl/cool_heat_fan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cool_heat_fan_ctrl_pkg : shared state encodings, default thresholds/duties
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cool_heat_fan_ctrl_pkg;

  localparam logic [1:0] c_ST_IDLE    = 2'b00;
  localparam logic [1:0] c_ST_HEATING = 2'b01;
  localparam logic [1:0] c_ST_COOLING = 2'b10;

  localparam logic [7:0] c_DEF_HEAT_ON  = 8'd15;
  localparam logic [7:0] c_DEF_HEAT_OFF = 8'd20;
  localparam logic [7:0] c_DEF_COOL_ON  = 8'd35;
  localparam logic [7:0] c_DEF_COOL_OFF = 8'd25;
  localparam logic [7:0] c_DEF_FAN_T1   = 8'd40;
  localparam logic [7:0] c_DEF_FAN_T2   = 8'd45;
  localparam logic [7:0] c_DEF_DUTY_LO  = 8'd64;
  localparam logic [7:0] c_DEF_DUTY_MID = 8'd128;
  localparam logic [7:0] c_DEF_DUTY_HI  = 8'd192;

  localparam logic [7:0] c_CNT_LAST = 8'hFF;

  // Fan duty for a temperature already known to be in the cooling regime.
  function automatic logic [7:0] band_duty(
    input logic [7:0] temp,
    input logic [7:0] t1,
    input logic [7:0] t2,
    input logic [7:0] lo,
    input logic [7:0] mid,
    input logic [7:0] hi
  );
    if (temp >= t2)      return hi;
    else if (temp >= t1) return mid;
    else                 return lo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cool_heat_fan_ctrl_if.sv
// ---------------------------------------------------------------------------
// cool_heat_fan_ctrl_if : temperature/counter inputs and actuator outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cool_heat_fan_ctrl_if;
  logic [7:0] temperature;
  logic [7:0] count;
  logic       heater_on;
  logic       cooler_on;
  logic       fan_pwm;
  logic [7:0] fan_duty;
  logic [1:0] mode;

  modport master (
    output temperature, count,
    input  heater_on, cooler_on, fan_pwm, fan_duty, mode
  );

  modport slave (
    input  temperature, count,
    output heater_on, cooler_on, fan_pwm, fan_duty, mode
  );
endinterface

`default_nettype wire

// File: rtl/cool_heat_fan_ctrl_pwm_compare.sv
// ---------------------------------------------------------------------------
// cool_heat_fan_ctrl_pwm_compare : period-boundary duty latch + registered PWM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cool_heat_fan_ctrl_pwm_compare
  import cool_heat_fan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] count,
  input  logic [7:0] duty_target,
  output logic [7:0] fan_duty,
  output logic       fan_pwm
);

  logic [7:0] r_fan_duty;
  logic       r_fan_pwm;

  // Duty only moves on the last count of a period so the PWM never glitches;
  // the compare uses the pre-update duty, which is harmless at count 0xFF.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_fan_duty <= '0;
      r_fan_pwm  <= 1'b0;
    end else begin
      if (count == c_CNT_LAST) begin
        r_fan_duty <= duty_target;
      end
      r_fan_pwm <= (count < r_fan_duty);
    end
  end

  assign fan_duty = r_fan_duty;
  assign fan_pwm  = r_fan_pwm;

endmodule

`default_nettype wire

// File: rtl/cool_heat_fan_ctrl.sv
// ---------------------------------------------------------------------------
// cool_heat_fan_ctrl : hysteresis heat/cool FSM with temperature-banded fan PWM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cool_heat_fan_ctrl
  import cool_heat_fan_ctrl_pkg::*;
#(
  parameter logic [7:0] HEAT_ON  = c_DEF_HEAT_ON,
  parameter logic [7:0] HEAT_OFF = c_DEF_HEAT_OFF,
  parameter logic [7:0] COOL_ON  = c_DEF_COOL_ON,
  parameter logic [7:0] COOL_OFF = c_DEF_COOL_OFF,
  parameter logic [7:0] FAN_T1   = c_DEF_FAN_T1,
  parameter logic [7:0] FAN_T2   = c_DEF_FAN_T2,
  parameter logic [7:0] DUTY_LO  = c_DEF_DUTY_LO,
  parameter logic [7:0] DUTY_MID = c_DEF_DUTY_MID,
  parameter logic [7:0] DUTY_HI  = c_DEF_DUTY_HI
) (
  input  logic                  clk,
  input  logic                  arst,
  cool_heat_fan_ctrl_if.slave   bus
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] w_duty_target;
  logic [7:0] w_fan_duty;
  logic       w_fan_pwm;

  // HEATING and COOLING always pass through IDLE; the unused code recovers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.temperature < HEAT_ON)      w_state_nxt = c_ST_HEATING;
        else if (bus.temperature > COOL_ON) w_state_nxt = c_ST_COOLING;
      end
      c_ST_HEATING: if (bus.temperature >= HEAT_OFF) w_state_nxt = c_ST_IDLE;
      c_ST_COOLING: if (bus.temperature <= COOL_OFF) w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) r_state <= c_ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_duty_target = '0;
    if (r_state == c_ST_COOLING) begin
      w_duty_target = band_duty(bus.temperature, FAN_T1, FAN_T2,
                                DUTY_LO, DUTY_MID, DUTY_HI);
    end
  end

  cool_heat_fan_ctrl_pwm_compare u_pwm (
    .clk         (clk),
    .arst        (arst),
    .count       (bus.count),
    .duty_target (w_duty_target),
    .fan_duty    (w_fan_duty),
    .fan_pwm     (w_fan_pwm)
  );

  assign bus.mode      = r_state;
  assign bus.heater_on = (r_state == c_ST_HEATING);
  assign bus.cooler_on = (r_state == c_ST_COOLING);
  assign bus.fan_duty  = w_fan_duty;
  assign bus.fan_pwm   = w_fan_pwm;

endmodule

`default_nettype wire

// File: tb/tb_cool_heat_fan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cool_heat_fan_ctrl : directed + random stimulus against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cool_heat_fan_ctrl;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  cool_heat_fan_ctrl_if bus ();

  cool_heat_fan_ctrl dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] temp_v;
  logic [7:0] cnt_v;
  logic       rst_v;

  // Model state: 0 idle, 1 heating, 2 cooling
  int m_mode;
  int m_duty;
  int m_pwm;

  function automatic int nxt_mode(input int m, input int t);
    if (m == 0) return (t < 15) ? 1 : ((t > 35) ? 2 : 0);
    if (m == 1) return (t >= 20) ? 0 : 1;
    return (t <= 25) ? 0 : 2;
  endfunction

  function automatic int tgt_duty(input int m, input int t);
    if (m != 2)  return 0;
    if (t >= 45) return 192;
    if (t >= 40) return 128;
    return 64;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit glitch);
    bus.temperature = temp_v;
    bus.count       = cnt_v;
    arst            = rst_v;
    if (glitch) begin
      #2 arst = 1'b1;
      #2 arst = 1'b0;
    end
    @(posedge clk);
    if (rst_v) begin
      m_mode = 0;
      m_duty = 0;
      m_pwm  = 0;
    end else begin
      m_pwm = (int'(cnt_v) < m_duty) ? 1 : 0;
      if (cnt_v == 8'hFF) m_duty = tgt_duty(m_mode, int'(temp_v));
      m_mode = nxt_mode(m_mode, int'(temp_v));
    end
    #1;
    chk("mode",      int'(bus.mode),      m_mode);
    chk("heater_on", int'(bus.heater_on), (m_mode == 1) ? 1 : 0);
    chk("cooler_on", int'(bus.cooler_on), (m_mode == 2) ? 1 : 0);
    chk("fan_duty",  int'(bus.fan_duty),  m_duty);
    chk("fan_pwm",   int'(bus.fan_pwm),   m_pwm);
    cnt_v = cnt_v + 8'd1;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic run_to(input logic [7:0] c);
    while (cnt_v != c) step(1'b0);
  endtask

  initial begin
    int hi;
    m_mode = 0; m_duty = 0; m_pwm = 0;

    // Reset with the counter running and a hot reading
    temp_v = 8'd50; cnt_v = 8'h80; rst_v = 1'b1;
    run(3);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_duty", int'(bus.fan_duty), 0);
    rst_v = 1'b0; temp_v = 8'd22;
    run(300);
    chk("idle_300", int'(bus.mode), 0);

    // Hysteresis boundaries
    temp_v = 8'd15; run(3);
    chk("t15_idle", int'(bus.mode), 0);
    temp_v = 8'd14; step(1'b0);
    chk("t14_heat", int'(bus.heater_on), 1);
    temp_v = 8'd19; run(3);
    chk("t19_hold", int'(bus.mode), 1);
    temp_v = 8'd20; step(1'b0);
    chk("t20_idle", int'(bus.mode), 0);
    temp_v = 8'd35; run(3);
    chk("t35_idle", int'(bus.mode), 0);
    temp_v = 8'd36; step(1'b0);
    chk("t36_cool", int'(bus.mode), 2);

    // Low band: 64 high cycles per period
    temp_v = 8'd38;
    run_to(8'hFF); step(1'b0);
    chk("duty_64", int'(bus.fan_duty), 64);
    hi = 0;
    repeat (256) begin
      step(1'b0);
      hi += int'(bus.fan_pwm);
    end
    chk("pwm_hi_64", hi, 64);

    // Mid-period temperature change waits for the boundary
    run_to(8'd100);
    temp_v = 8'd46;
    run(20);
    chk("duty_hold_64", int'(bus.fan_duty), 64);
    run_to(8'hFF); step(1'b0);
    chk("duty_192", int'(bus.fan_duty), 192);
    run(20);
    temp_v = 8'd30; run(5);
    chk("t30_cool", int'(bus.mode), 2);
    temp_v = 8'd25; step(1'b0);
    chk("t25_idle", int'(bus.mode), 0);
    chk("duty_keep", int'(bus.fan_duty), 192);
    run_to(8'hFF); step(1'b0);
    chk("duty_0", int'(bus.fan_duty), 0);

    // Counter skips 0xFF: no duty update that period
    temp_v = 8'd40; run(3);
    run_to(8'hF0); step(1'b0);
    cnt_v = 8'h05; temp_v = 8'd46;
    run(10);
    chk("skip_ff", int'(bus.fan_duty), 0);
    run_to(8'hFF); step(1'b0);
    chk("after_skip", int'(bus.fan_duty), 192);
    temp_v = 8'd42;
    run_to(8'hFF); step(1'b0);
    chk("duty_128", int'(bus.fan_duty), 128);

    // Mid-period reset, then an unsampled pulse between edges
    run_to(8'd50);
    rst_v = 1'b1; step(1'b0); rst_v = 1'b0;
    chk("mid_rst_duty", int'(bus.fan_duty), 0);
    chk("mid_rst_mode", int'(bus.mode), 0);
    run(5);
    repeat (4) step(1'b1);
    chk("glitch_mode", int'(bus.mode), 2);

    // Randomized soak
    repeat (6000) begin
      if ($urandom_range(0, 3) == 0) temp_v = 8'($urandom_range(8, 52));
      if ($urandom_range(0, 63) == 0) cnt_v = 8'($urandom);
      rst_v = ($urandom_range(0, 999) == 0);
      step(1'b0);
    end
    rst_v = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
